// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types and helpers for the dual-port clearable SRAM
package sram_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } sram_state_t;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    function automatic int lane_count(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/sram_clr_seq.sv
// rtl/sram_clr_seq.sv - clear sweep FSM and fill address counter
module sram_clr_seq
    import sram_pkg::*;
#(
    parameter int AW         = 10,
    parameter int POL        = 1,
    parameter int CLR_ON_RST = 1
) (
    input  logic          i_MCLK,
    input  logic          i_RST_n,
    input  logic          i_CLR,
    output logic          busy,
    output logic [AW-1:0] fill_addr,
    output logic          fill_we
);

    localparam logic [AW-1:0] LAST = '1;

    sram_state_t   state;
    logic [AW-1:0] cnt;

    assign fill_addr = cnt;
    assign fill_we   = (state == ST_CLEAR);

    // Leaving on the terminal count keeps the sweep from re-entering the array.
    generate
        if (POL != 0) begin : g_pos
            always_ff @(posedge i_MCLK) begin
                if (!i_RST_n) begin
                    cnt   <= '0;
                    state <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
                    busy  <= (CLR_ON_RST != 0);
                end else begin
                    case (state)
                        ST_IDLE: begin
                            if (i_CLR) begin
                                state <= ST_CLEAR;
                                cnt   <= '0;
                                busy  <= 1'b1;
                            end
                        end
                        ST_CLEAR: begin
                            if (cnt == LAST) begin
                                state <= ST_IDLE;
                                cnt   <= '0;
                                busy  <= 1'b0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end
        end else begin : g_neg
            always_ff @(negedge i_MCLK) begin
                if (!i_RST_n) begin
                    cnt   <= '0;
                    state <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
                    busy  <= (CLR_ON_RST != 0);
                end else begin
                    case (state)
                        ST_IDLE: begin
                            if (i_CLR) begin
                                state <= ST_CLEAR;
                                cnt   <= '0;
                                busy  <= 1'b1;
                            end
                        end
                        ST_CLEAR: begin
                            if (cnt == LAST) begin
                                state <= ST_IDLE;
                                cnt   <= '0;
                                busy  <= 1'b0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end
        end
    endgenerate

endmodule

// File: rtl/sram_dp_clr.sv
// rtl/sram_dp_clr.sv - true dual-port SRAM with byte enables and clear sweep
module sram_dp_clr
    import sram_pkg::*;
#(
    parameter int            DW         = 8,
    parameter int            AW         = 10,
    parameter int            POL        = 1,
    parameter int            RDW        = 0,
    parameter int            CLR_ON_RST = 1,
    parameter logic [DW-1:0] CLR_VAL    = '0,
    parameter                simhexfile = ""
) (
    input  logic                     i_MCLK,
    input  logic                     i_RST_n,
    input  logic                     i_CLR,
    output logic                     o_BUSY,
    input  logic [AW-1:0]            i_ADDRA,
    input  logic [AW-1:0]            i_ADDRB,
    input  logic [DW-1:0]            i_DINA,
    input  logic [DW-1:0]            i_DINB,
    input  logic [lane_count(DW)-1:0] i_BEA_n,
    input  logic [lane_count(DW)-1:0] i_BEB_n,
    input  logic                     i_CSA_n,
    input  logic                     i_CSB_n,
    input  logic                     i_RDA_n,
    input  logic                     i_RDB_n,
    input  logic                     i_WRA_n,
    input  logic                     i_WRB_n,
    output logic [DW-1:0]            o_DOUTA,
    output logic [DW-1:0]            o_DOUTB
);

    localparam int LANES = lane_count(DW);
    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0]    mem [DEPTH];
    logic [AW-1:0]    fill_addr;
    logic             fill_we;
    logic [AW-1:0]    wa_addr;
    logic [DW-1:0]    wa_data;
    logic [LANES-1:0] wa_be;
    logic [LANES-1:0] wb_be;
    logic             rd_a;
    logic             rd_b;
    logic [DW-1:0]    rdata_a;
    logic [DW-1:0]    rdata_b;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                            input logic [DW-1:0] din,
                                            input logic [LANES-1:0] be);
        logic [DW-1:0] w;
        w = old;
        for (int k = 0; k < LANES; k++) begin
            if (be[k]) w[8*k +: 8] = din[8*k +: 8];
        end
        return w;
    endfunction

    sram_clr_seq #(
        .AW         (AW),
        .POL        (POL),
        .CLR_ON_RST (CLR_ON_RST)
    ) u_clr_seq (
        .i_MCLK    (i_MCLK),
        .i_RST_n   (i_RST_n),
        .i_CLR     (i_CLR),
        .busy      (o_BUSY),
        .fill_addr (fill_addr),
        .fill_we   (fill_we)
    );

    // The sweep borrows port A's write path and locks both ports out.
    always_comb begin
        wa_addr = i_ADDRA;
        wa_data = i_DINA;
        wa_be   = '0;
        wb_be   = '0;
        if (fill_we) begin
            wa_addr = fill_addr;
            wa_data = CLR_VAL;
            wa_be   = '1;
        end else begin
            if (!i_CSA_n && !i_WRA_n) wa_be = ~i_BEA_n;
            if (!i_CSB_n && !i_WRB_n) wb_be = ~i_BEB_n;
        end
    end

    assign rd_a = !fill_we && !i_CSA_n && !i_RDA_n;
    assign rd_b = !fill_we && !i_CSB_n && !i_RDB_n;

    // B merges before A so the forwarded word matches A's lane priority.
    always_comb begin
        rdata_a = mem[i_ADDRA];
        rdata_b = mem[i_ADDRB];
        if (RDW == RDW_NEW) begin
            if (i_ADDRB == i_ADDRA) rdata_a = merge(rdata_a, i_DINB, wb_be);
            if (wa_addr == i_ADDRA) rdata_a = merge(rdata_a, wa_data, wa_be);
            rdata_b = merge(rdata_b, i_DINB, wb_be);
            if (wa_addr == i_ADDRB) rdata_b = merge(rdata_b, wa_data, wa_be);
        end
    end

    generate
        if (POL != 0) begin : g_pos
            always_ff @(posedge i_MCLK) begin
                if (!i_RST_n) begin
                    o_DOUTA <= '0;
                    o_DOUTB <= '0;
                end else begin
                    if (rd_a) o_DOUTA <= rdata_a;
                    if (rd_b) o_DOUTB <= rdata_b;
                    for (int k = 0; k < LANES; k++) begin
                        if (wb_be[k]) mem[i_ADDRB][8*k +: 8] <= i_DINB[8*k +: 8];
                        if (wa_be[k]) mem[wa_addr][8*k +: 8] <= wa_data[8*k +: 8];
                    end
                end
            end
        end else begin : g_neg
            always_ff @(negedge i_MCLK) begin
                if (!i_RST_n) begin
                    o_DOUTA <= '0;
                    o_DOUTB <= '0;
                end else begin
                    if (rd_a) o_DOUTA <= rdata_a;
                    if (rd_b) o_DOUTB <= rdata_b;
                    for (int k = 0; k < LANES; k++) begin
                        if (wb_be[k]) mem[i_ADDRB][8*k +: 8] <= i_DINB[8*k +: 8];
                        if (wa_be[k]) mem[wa_addr][8*k +: 8] <= wa_data[8*k +: 8];
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_sram_dp_clr.sv
// tb/tb_sram_dp_clr.sv - self-checking bench for sram_dp_clr (old and new RDW instances)
module tb_sram_dp_clr;

    localparam logic [15:0] CLR0 = 16'hA5A5;
    localparam logic [15:0] CLR1 = 16'h0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, clr;
    logic [3:0]  addra, addrb;
    logic [15:0] dina, dinb;
    logic [1:0]  bea_n, beb_n;
    logic        csa_n, csb_n, rda_n, rdb_n, wra_n, wrb_n;
    logic        busy0, busy1;
    logic [15:0] douta0, doutb0, douta1, doutb1;

    int total = 0;
    int bad   = 0;

    logic [15:0] mm [2][16];
    logic [15:0] ma [2];
    logic [15:0] mb [2];
    bit          mbusy;
    int          mptr;

    sram_dp_clr #(.DW(16), .AW(4), .POL(1), .RDW(0), .CLR_ON_RST(1), .CLR_VAL(CLR0)) u_old (
        .i_MCLK(clk), .i_RST_n(rst_n), .i_CLR(clr), .o_BUSY(busy0),
        .i_ADDRA(addra), .i_ADDRB(addrb), .i_DINA(dina), .i_DINB(dinb),
        .i_BEA_n(bea_n), .i_BEB_n(beb_n), .i_CSA_n(csa_n), .i_CSB_n(csb_n),
        .i_RDA_n(rda_n), .i_RDB_n(rdb_n), .i_WRA_n(wra_n), .i_WRB_n(wrb_n),
        .o_DOUTA(douta0), .o_DOUTB(doutb0)
    );

    sram_dp_clr #(.DW(16), .AW(4), .POL(1), .RDW(1), .CLR_ON_RST(1), .CLR_VAL(CLR1)) u_new (
        .i_MCLK(clk), .i_RST_n(rst_n), .i_CLR(clr), .o_BUSY(busy1),
        .i_ADDRA(addra), .i_ADDRB(addrb), .i_DINA(dina), .i_DINB(dinb),
        .i_BEA_n(bea_n), .i_BEB_n(beb_n), .i_CSA_n(csa_n), .i_CSB_n(csb_n),
        .i_RDA_n(rda_n), .i_RDB_n(rdb_n), .i_WRA_n(wra_n), .i_WRB_n(wrb_n),
        .o_DOUTA(douta1), .o_DOUTB(doutb1)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        csa_n = 1'b1; rda_n = 1'b1; wra_n = 1'b1; addra = 4'h0; dina = 16'h0; bea_n = 2'b11;
        csb_n = 1'b1; rdb_n = 1'b1; wrb_n = 1'b1; addrb = 4'h0; dinb = 16'h0; beb_n = 2'b11;
    endtask

    task automatic set_a(input logic r_n, input logic w_n, input logic [3:0] a,
                         input logic [15:0] d, input logic [1:0] be);
        rda_n = r_n; wra_n = w_n; csa_n = r_n & w_n; addra = a; dina = d; bea_n = be;
    endtask

    task automatic set_b(input logic r_n, input logic w_n, input logic [3:0] a,
                         input logic [15:0] d, input logic [1:0] be);
        rdb_n = r_n; wrb_n = w_n; csb_n = r_n & w_n; addrb = a; dinb = d; beb_n = be;
    endtask

    // Whole-array view: build the post-write array, then pick old or new word.
    task automatic model_step();
        logic [15:0] nw [16];
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                ma[d] = 16'h0;
                mb[d] = 16'h0;
            end else if (mbusy) begin
                mm[d][mptr] = (d == 0) ? CLR0 : CLR1;
            end else begin
                nw = mm[d];
                for (int k = 0; k < 2; k++)
                    if (!csb_n && !wrb_n && !beb_n[k]) nw[addrb][8*k +: 8] = dinb[8*k +: 8];
                for (int k = 0; k < 2; k++)
                    if (!csa_n && !wra_n && !bea_n[k]) nw[addra][8*k +: 8] = dina[8*k +: 8];
                if (!csa_n && !rda_n) ma[d] = (d == 1) ? nw[addra] : mm[d][addra];
                if (!csb_n && !rdb_n) mb[d] = (d == 1) ? nw[addrb] : mm[d][addrb];
                mm[d] = nw;
            end
        end
        if (!rst_n) begin
            mbusy = 1'b1;
            mptr  = 0;
        end else if (mbusy) begin
            mptr++;
            if (mptr == 16) mbusy = 1'b0;
        end else if (clr) begin
            mbusy = 1'b1;
            mptr  = 0;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("douta_old", douta0, ma[0]);
        chk("doutb_old", doutb0, mb[0]);
        chk("douta_new", douta1, ma[1]);
        chk("doutb_new", doutb1, mb[1]);
        chk("busy_old", 16'(busy0), 16'(mbusy));
        chk("busy_new", 16'(busy1), 16'(mbusy));
    endtask

    task automatic wait_idle(input string tag, input int n0);
        int n;
        n = n0;
        while (busy0 && n < 40) begin
            cycle();
            n++;
        end
        chk(tag, 16'(n), 16'd16);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        idle_in();
        rst_n = 1'b0;
        clr   = 1'b0;
        mbusy = 1'b0;
        mptr  = 0;
        ma[0] = 16'h0; ma[1] = 16'h0; mb[0] = 16'h0; mb[1] = 16'h0;

        // reset state and automatic sweep length
        cycle();
        chk("rst_douta", douta0, 16'h0000);
        chk("rst_busy", 16'(busy0), 16'd1);
        rst_n = 1'b1;
        wait_idle("t1_busy_len", 0);

        // every word holds the fill value
        for (int a = 0; a < 16; a++) begin
            set_a(1'b0, 1'b1, 4'(a), 16'h0, 2'b11);
            cycle();
            chk("t1_fill_old", douta0, CLR0);
            chk("t1_fill_new", douta1, CLR1);
        end
        idle_in();

        // byte-lane merge
        set_a(1'b1, 1'b0, 4'h3, 16'h1234, 2'b00); cycle();
        set_a(1'b1, 1'b0, 4'h3, 16'hFFEE, 2'b10); cycle();
        idle_in();
        set_b(1'b0, 1'b1, 4'h3, 16'h0, 2'b11); cycle();
        chk("t2_lane_old", doutb0, 16'h12EE);
        chk("t2_lane_new", doutb1, 16'h12EE);
        idle_in();

        // cross-port read-during-write
        set_a(1'b1, 1'b0, 4'h7, 16'h0011, 2'b00); cycle();
        set_a(1'b1, 1'b0, 4'h7, 16'h0055, 2'b00);
        set_b(1'b0, 1'b1, 4'h7, 16'h0, 2'b11); cycle();
        chk("t3_rdw_old", doutb0, 16'h0011);
        chk("t3_rdw_new", doutb1, 16'h0055);
        idle_in();
        set_b(1'b0, 1'b1, 4'h7, 16'h0, 2'b11); cycle();
        chk("t3_after_old", doutb0, 16'h0055);
        idle_in();

        // write collisions: full and lane-split
        set_a(1'b1, 1'b0, 4'h9, 16'hAAAA, 2'b00);
        set_b(1'b1, 1'b0, 4'h9, 16'hBBBB, 2'b00); cycle();
        idle_in();
        set_b(1'b0, 1'b1, 4'h9, 16'h0, 2'b11); cycle();
        chk("t4_coll_old", doutb0, 16'hAAAA);
        chk("t4_coll_new", doutb1, 16'hAAAA);
        set_a(1'b1, 1'b0, 4'h9, 16'h00CC, 2'b10);
        set_b(1'b1, 1'b0, 4'h9, 16'hDDDD, 2'b00); cycle();
        idle_in();
        set_a(1'b0, 1'b1, 4'h9, 16'h0, 2'b11); cycle();
        chk("t4_split_old", douta0, 16'hDDCC);
        chk("t4_split_new", douta1, 16'hDDCC);
        idle_in();

        // clear request, ignored re-request, reset mid-sweep, dropped access
        clr = 1'b1; cycle(); clr = 1'b0;
        chk("t5_clr_busy", 16'(busy0), 16'd1);
        cycle(); cycle();
        clr = 1'b1; cycle(); clr = 1'b0;
        cycle();
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        n = 0;
        repeat (5) begin cycle(); n++; end
        set_a(1'b1, 1'b0, 4'h2, 16'h0077, 2'b00);
        set_b(1'b0, 1'b1, 4'h2, 16'h0, 2'b11);
        cycle(); n++;
        idle_in();
        chk("t6_hold_old", doutb0, 16'h0000);
        wait_idle("t5_busy_len", n);
        set_a(1'b0, 1'b1, 4'h2, 16'h0, 2'b11); cycle();
        chk("t6_drop_old", douta0, CLR0);
        chk("t6_drop_new", douta1, CLR1);
        idle_in();

        // randomized traffic with occasional clears and resets
        for (int i = 0; i < 400; i++) begin
            csa_n = ($urandom_range(0, 3) == 0);
            rda_n = 1'($urandom_range(0, 1));
            wra_n = 1'($urandom_range(0, 1));
            bea_n = 2'($urandom_range(0, 3));
            addra = 4'($urandom_range(0, 15));
            dina  = 16'($urandom);
            csb_n = ($urandom_range(0, 3) == 0);
            rdb_n = 1'($urandom_range(0, 1));
            wrb_n = 1'($urandom_range(0, 1));
            beb_n = 2'($urandom_range(0, 3));
            addrb = ($urandom_range(0, 2) == 0) ? addra : 4'($urandom_range(0, 15));
            dinb  = 16'($urandom);
            clr   = ($urandom_range(0, 59) == 0);
            rst_n = ($urandom_range(0, 199) != 0);
            cycle();
        end
        idle_in();
        clr   = 1'b0;
        rst_n = 1'b1;
        n = 0;
        while (busy0 && n < 40) begin cycle(); n++; end
        chk("drain_busy", 16'(busy0), 16'd0);

        // final sweep of the array on both ports
        for (int a = 0; a < 16; a++) begin
            set_a(1'b0, 1'b1, 4'(a), 16'h0, 2'b11);
            set_b(1'b0, 1'b1, 4'(15 - a), 16'h0, 2'b11);
            cycle();
        end
        idle_in();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
